// File: rtl/eval_sequencer_pkg.sv
// rtl/eval_sequencer_pkg.sv - shared state encoding, widths and helpers for the eval sequencer
package eval_sequencer_pkg;

    localparam int BOARD_WIDTH    = 64;
    localparam int EVAL_PHASE_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SUM   = 3'd2,
        ST_TAPER = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // PHASE_MAX is a power of two, so the taper divide is a plain shift
    function automatic int phase_shift(input int phase_max);
        return $clog2(phase_max);
    endfunction

endpackage

// File: rtl/eval_taper.sv
// rtl/eval_taper.sv - combinational phase taper: blend mg/eg sums, floor-shift, saturate
module eval_taper
    import eval_sequencer_pkg::*;
#(
    parameter int EVAL_WIDTH  = 24,
    parameter int SUM_WIDTH   = 28,
    parameter int PHASE_WIDTH = 6,
    parameter int PHASE_MAX   = EVAL_PHASE_MAX
) (
    input  logic signed [SUM_WIDTH-1:0]  mg_sum,
    input  logic signed [SUM_WIDTH-1:0]  eg_sum,
    input  logic        [PHASE_WIDTH-1:0] phase,
    output logic signed [EVAL_WIDTH-1:0] eval
);

    localparam int PROD_WIDTH = SUM_WIDTH + PHASE_WIDTH + 2;
    localparam int SHIFT      = phase_shift(PHASE_MAX);
    localparam logic signed [PROD_WIDTH-1:0] EVAL_MAX =
        {{(PROD_WIDTH-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
    localparam logic signed [PROD_WIDTH-1:0] EVAL_MIN =
        {{(PROD_WIDTH-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

    logic signed [PROD_WIDTH-1:0] mg_ext;
    logic signed [PROD_WIDTH-1:0] eg_ext;
    logic signed [PROD_WIDTH-1:0] mg_weight;
    logic signed [PROD_WIDTH-1:0] eg_weight;
    logic signed [PROD_WIDTH-1:0] blend;
    logic signed [PROD_WIDTH-1:0] scaled;

    always_comb begin
        mg_ext    = {{(PROD_WIDTH-SUM_WIDTH){mg_sum[SUM_WIDTH-1]}}, mg_sum};
        eg_ext    = {{(PROD_WIDTH-SUM_WIDTH){eg_sum[SUM_WIDTH-1]}}, eg_sum};
        mg_weight = {{(PROD_WIDTH-PHASE_WIDTH){1'b0}}, phase};
        eg_weight = PROD_WIDTH'(PHASE_MAX) - mg_weight;
        blend     = mg_ext * mg_weight + eg_ext * eg_weight;
        // arithmetic shift floors toward -inf, matching the scoring convention
        scaled    = blend >>> SHIFT;
        if (scaled > EVAL_MAX) begin
            eval = EVAL_MAX[EVAL_WIDTH-1:0];
        end else if (scaled < EVAL_MIN) begin
            eval = EVAL_MIN[EVAL_WIDTH-1:0];
        end else begin
            eval = scaled[EVAL_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/eval_sequencer.sv
// rtl/eval_sequencer.sv - launches a board to all eval units, gathers, sums and tapers their scores
module eval_sequencer
    import eval_sequencer_pkg::*;
#(
    parameter int EVAL_WIDTH     = 24,
    parameter int NUM_EVAL       = 4,
    parameter int PHASE_WIDTH    = 6,
    parameter int PHASE_MAX      = EVAL_PHASE_MAX,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           board_valid,
    input  logic [BOARD_WIDTH-1:0]         board,
    input  logic [PHASE_WIDTH-1:0]         phase,
    input  logic                           clear_eval,
    output logic                           busy,
    output logic signed [EVAL_WIDTH-1:0]   eval,
    output logic                           eval_error,
    output logic                           eval_valid,
    output logic                           unit_board_valid,
    output logic [BOARD_WIDTH-1:0]         unit_board,
    output logic                           unit_clear_eval,
    input  logic [NUM_EVAL*EVAL_WIDTH-1:0] unit_eval_mg,
    input  logic [NUM_EVAL*EVAL_WIDTH-1:0] unit_eval_eg,
    input  logic [NUM_EVAL-1:0]            unit_eval_valid
);

    localparam int SUM_WIDTH = EVAL_WIDTH + 4;
    localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t state_q;
    seq_state_t state_d;

    logic [NUM_EVAL-1:0]          seen_q;
    logic [NUM_EVAL-1:0]          seen_d;
    logic [TMO_WIDTH-1:0]         tmo_q;
    logic [PHASE_WIDTH-1:0]       phase_q;
    logic [PHASE_WIDTH-1:0]       phase_clamped;
    logic signed [SUM_WIDTH-1:0]  mg_sum_q;
    logic signed [SUM_WIDTH-1:0]  eg_sum_q;
    logic signed [SUM_WIDTH-1:0]  mg_acc;
    logic signed [SUM_WIDTH-1:0]  eg_acc;
    logic signed [EVAL_WIDTH-1:0] mg_term;
    logic signed [EVAL_WIDTH-1:0] eg_term;
    logic signed [EVAL_WIDTH-1:0] taper_eval;

    logic launch;
    logic abort;
    logic finish;
    logic timeout_hit;
    logic done_clear;

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        phase_clamped = (phase > PHASE_WIDTH'(PHASE_MAX)) ? PHASE_WIDTH'(PHASE_MAX) : phase;
    end

    always_comb begin
        mg_acc  = '0;
        eg_acc  = '0;
        mg_term = '0;
        eg_term = '0;
        for (int k = 0; k < NUM_EVAL; k++) begin
            mg_term = unit_eval_mg[k*EVAL_WIDTH +: EVAL_WIDTH];
            eg_term = unit_eval_eg[k*EVAL_WIDTH +: EVAL_WIDTH];
            mg_acc  = mg_acc + $signed({{4{mg_term[EVAL_WIDTH-1]}}, mg_term});
            eg_acc  = eg_acc + $signed({{4{eg_term[EVAL_WIDTH-1]}}, eg_term});
        end
    end

    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        abort       = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        done_clear  = 1'b0;
        seen_d      = seen_q | unit_eval_valid;
        case (state_q)
            ST_IDLE: begin
                if (board_valid) begin
                    launch  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (clear_eval) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (&seen_d) begin
                    state_d = ST_SUM;
                end else if (tmo_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_SUM: begin
                if (clear_eval) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TAPER;
                end
            end
            ST_TAPER: begin
                if (clear_eval) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clear_eval) begin
                    done_clear = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            seen_q           <= '0;
            tmo_q            <= '0;
            phase_q          <= '0;
            mg_sum_q         <= '0;
            eg_sum_q         <= '0;
            eval             <= '0;
            eval_error       <= 1'b0;
            eval_valid       <= 1'b0;
            unit_board_valid <= 1'b0;
            unit_board       <= '0;
            unit_clear_eval  <= 1'b0;
        end else begin
            state_q          <= state_d;
            unit_board_valid <= launch;
            // units are cleared on every exit from the evaluation, successful or not
            unit_clear_eval  <= abort | finish | timeout_hit;
            if (launch) begin
                unit_board <= board;
                phase_q    <= phase_clamped;
                seen_q     <= '0;
                tmo_q      <= '0;
            end
            if (state_q == ST_WAIT) begin
                seen_q <= seen_d;
                tmo_q  <= tmo_q + TMO_WIDTH'(1);
            end
            if (state_q == ST_SUM) begin
                mg_sum_q <= mg_acc;
                eg_sum_q <= eg_acc;
            end
            if (finish) begin
                eval       <= taper_eval;
                eval_error <= 1'b0;
                eval_valid <= 1'b1;
            end
            if (timeout_hit) begin
                eval       <= '0;
                eval_error <= 1'b1;
                eval_valid <= 1'b1;
            end
            if (done_clear) begin
                eval_error <= 1'b0;
                eval_valid <= 1'b0;
            end
        end
    end

    eval_taper #(
        .EVAL_WIDTH  (EVAL_WIDTH),
        .SUM_WIDTH   (SUM_WIDTH),
        .PHASE_WIDTH (PHASE_WIDTH),
        .PHASE_MAX   (PHASE_MAX)
    ) u_taper (
        .mg_sum (mg_sum_q),
        .eg_sum (eg_sum_q),
        .phase  (phase_q),
        .eval   (taper_eval)
    );

endmodule

// File: tb/tb_eval_sequencer.sv
// tb/tb_eval_sequencer.sv - scoreboard bench for eval_sequencer with a behavioural taper model
module tb_eval_sequencer;
    import eval_sequencer_pkg::*;

    localparam int EW   = 24;
    localparam int NE   = 4;
    localparam int PW   = 6;
    localparam int PMAX = 32;
    localparam int TMO  = 64;
    localparam int BW   = BOARD_WIDTH;
    localparam longint EMAX = (64'sd1 <<< (EW - 1)) - 1;
    localparam longint EMIN = -(64'sd1 <<< (EW - 1));

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  board_valid;
    logic [BW-1:0]         board;
    logic [PW-1:0]         phase;
    logic                  clear_eval;
    logic                  busy;
    logic signed [EW-1:0]  eval;
    logic                  eval_error;
    logic                  eval_valid;
    logic                  unit_board_valid;
    logic [BW-1:0]         unit_board;
    logic                  unit_clear_eval;
    logic [NE*EW-1:0]      unit_eval_mg;
    logic [NE*EW-1:0]      unit_eval_eg;
    logic [NE-1:0]         unit_eval_valid;

    eval_sequencer #(
        .EVAL_WIDTH(EW), .NUM_EVAL(NE), .PHASE_WIDTH(PW), .PHASE_MAX(PMAX), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .board_valid(board_valid), .board(board), .phase(phase),
        .clear_eval(clear_eval), .busy(busy), .eval(eval), .eval_error(eval_error),
        .eval_valid(eval_valid), .unit_board_valid(unit_board_valid), .unit_board(unit_board),
        .unit_clear_eval(unit_clear_eval), .unit_eval_mg(unit_eval_mg),
        .unit_eval_eg(unit_eval_eg), .unit_eval_valid(unit_eval_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint ev;
        bit     err;
        int     cyc;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_launch = 0;
    int     n_uclr = 0;
    int     exp_launch = 0;
    int     exp_uclr = 0;
    logic   prev_ev = 1'b0;
    longint mgv[NE];
    longint egv[NE];
    int     dly[NE];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference score: exact weighted blend, floor division, clamp to the signed output range
    function automatic longint ref_eval(input longint mgs, input longint egs, input int p);
        longint pe, num, q;
        pe  = (p > PMAX) ? PMAX : p;
        num = mgs * pe + egs * (PMAX - pe);
        q   = num / PMAX;
        if ((num % PMAX != 0) && (num < 0)) q = q - 1;
        if (q > EMAX) q = EMAX;
        if (q < EMIN) q = EMIN;
        return q;
    endfunction

    function automatic longint rnd_val();
        logic signed [EW-1:0] t;
        if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 2000)) - 1000;
        t = EW'($urandom);
        return longint'(t);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (unit_board_valid) n_launch++;
            if (unit_clear_eval) n_uclr++;
        end
        if (eval_valid && !prev_ev) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("eval", longint'(eval), mon_e.ev);
                check("eval_error", longint'(eval_error), longint'(mon_e.err));
                check("result_latency", cyc, mon_e.cyc);
            end
        end
        prev_ev = eval_valid;
    end

    // stop_at > 0: clear_eval (or reset, if by_reset) at that cycle after launch
    task automatic run_txn(input int p, input bit pulse_mode, input int stop_at, input bit by_reset);
        longint     mgs, egs;
        int         dmax, b;
        bit         never, got, stopped;
        exp_t       e;
        logic [BW-1:0] bd;
        mgs = 0; egs = 0; dmax = 0; never = 0; got = 0; stopped = 0;
        for (int k = 0; k < NE; k++) begin
            mgs += mgv[k];
            egs += egv[k];
            if (dly[k] < 0) never = 1;
            else if (dly[k] > dmax) dmax = dly[k];
            unit_eval_mg[k*EW +: EW] = mgv[k][EW-1:0];
            unit_eval_eg[k*EW +: EW] = egv[k][EW-1:0];
        end
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("idle_before_launch", longint'(busy), 0);
        bd = {$urandom, $urandom};
        board = bd;
        phase = PW'(p);
        board_valid = 1'b1;
        b = cyc;
        if (stop_at <= 0) begin
            e.err = never;
            e.ev  = never ? 0 : ref_eval(mgs, egs, p);
            e.cyc = never ? b + 1 + TMO : b + dmax + 3;
            sbq.push_back(e);
        end
        exp_launch++;
        if (!by_reset) exp_uclr++;
        @(negedge clk);
        board_valid = 1'b0;
        check("launch_pulse", longint'(unit_board_valid), 1);
        check("unit_board", longint'(unit_board), longint'(bd));
        for (int i = 1; i <= TMO + 10; i++) begin
            for (int k = 0; k < NE; k++) begin
                if (pulse_mode) unit_eval_valid[k] = (dly[k] == i);
                else            unit_eval_valid[k] = (dly[k] >= 0) && (dly[k] <= i);
            end
            board_valid = (i == 2);
            if (i == stop_at && by_reset) begin
                board_valid = 1'b0;
                reset = 1'b1;
                repeat (3) @(negedge clk);
                check("rst_busy", longint'(busy), 0);
                check("rst_eval_valid", longint'(eval_valid), 0);
                check("rst_eval", longint'(eval), 0);
                check("rst_unit_board", longint'(unit_board), 0);
                check("rst_unit_pulses", longint'({unit_board_valid, unit_clear_eval, eval_error}), 0);
                reset = 1'b0;
                stopped = 1;
                break;
            end
            clear_eval = (i == stop_at);
            @(negedge clk);
            board_valid = 1'b0;
            if (i == stop_at) begin
                clear_eval = 1'b0;
                check("abort_unit_clear", longint'(unit_clear_eval), 1);
                check("abort_idle", longint'(busy), 0);
                stopped = 1;
                break;
            end
            if (eval_valid) begin
                got = 1;
                break;
            end
        end
        unit_eval_valid = '0;
        if (stopped) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check("no_result_after_stop", longint'(eval_valid), 0);
            end
        end else if (!got) begin
            check("result_timeout", 0, 1);
        end else begin
            check("clear_pulse_entry", longint'(unit_clear_eval), 1);
            @(negedge clk);
            check("clear_pulse_single", longint'(unit_clear_eval), 0);
            check("eval_valid_held", longint'(eval_valid), 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            clear_eval  = 1'b1;
            board_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            clear_eval  = 1'b0;
            board_valid = 1'b0;
            check("released_valid", longint'(eval_valid), 0);
            check("released_error", longint'(eval_error), 0);
            check("released_busy", longint'(busy), 0);
            check("no_launch_on_clear", longint'(unit_board_valid), 0);
        end
    endtask

    task automatic set_units(input longint m0, input longint m1, input longint m2, input longint m3,
                             input longint e0, input longint e1, input longint e2, input longint e3,
                             input int d0, input int d1, input int d2, input int d3);
        mgv[0] = m0; mgv[1] = m1; mgv[2] = m2; mgv[3] = m3;
        egv[0] = e0; egv[1] = e1; egv[2] = e2; egv[3] = e3;
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    int mode;
    int dm;

    initial begin
        reset = 1'b1; board_valid = 1'b0; clear_eval = 1'b0; board = '0; phase = '0;
        unit_eval_mg = '0; unit_eval_eg = '0; unit_eval_valid = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_eval_valid", longint'(eval_valid), 0);
        check("reset_outputs", longint'({eval, eval_error, unit_board_valid, unit_clear_eval}), 0);
        reset = 1'b0;
        @(negedge clk);

        set_units(5, 5, 5, 5, 1, 1, 1, 1, -1, -1, -1, -1);
        run_txn(20, 0, 4, 1);
        set_units(35, 20, -10, 0, 0, 0, 0, 0, 5, 5, 5, 5);
        run_txn(32, 0, -1, 0);
        set_units(10, 10, 10, 10, 5, 5, 5, 5, 3, 7, 2, 4);
        run_txn(16, 0, -1, 0);
        set_units(-35, 0, 0, 0, 0, 0, 0, 0, 6, 1, 1, 1);
        run_txn(16, 1, -1, 0);
        set_units(3, 4, 0, 0, 50, 49, 0, 0, 2, 2, 2, 2);
        run_txn(40, 0, -1, 0);
        set_units(1, 2, 3, 4, -5, -6, -7, -8, 5, 5, 5, 15);
        run_txn(7, 1, -1, 0);
        set_units(9, 9, 9, 9, 9, 9, 9, 9, 3, 4, -1, 6);
        run_txn(10, 0, -1, 0);
        set_units(1, 1, 1, 1, 1, 1, 1, 1, 10, 10, 10, 10);
        run_txn(12, 0, 3, 0);
        set_units(EMAX, EMAX, EMAX, EMAX, 0, 0, 0, 0, 1, 2, 3, 4);
        run_txn(32, 0, -1, 0);
        set_units(EMIN, EMIN, EMIN, EMIN, EMIN, EMIN, EMIN, EMIN, 4, 3, 2, 1);
        run_txn(5, 0, -1, 0);
        set_units(0, 0, 0, 0, -31, 0, 0, 0, 1, 1, 1, 1);
        run_txn(0, 0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 7));
            dm = 1;
            for (int k = 0; k < NE; k++) begin
                mgv[k] = rnd_val();
                egv[k] = rnd_val();
                dly[k] = int'($urandom_range(1, 20));
                if (dly[k] > dm) dm = dly[k];
            end
            if (mode == 0) dly[$urandom_range(0, NE - 1)] = -1;
            run_txn(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                    (mode == 1) ? int'($urandom_range(1, dm + 2)) : -1, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("launch_count", n_launch, exp_launch);
        check("unit_clear_count", n_uclr, exp_uclr);
        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eval_sequencer.md
Name: eval_sequencer

Overview:
Controller that owns a bank of NUM_EVAL evaluation units (rooks, pawns, mobility, …), each with the board_valid / clear_eval / eval_mg / eval_eg / eval_valid contract. It accepts one board from the search side and broadcasts it to all units. It waits for every unit's eval_valid, sums the midgame and endgame terms, tapers them by game phase and returns a single signed score. It then clears the units for the next board.

Parameters:
EVAL_WIDTH, 24, signed width of each unit's eval_mg/eval_eg and of the output score
NUM_EVAL, 4, number of evaluation units sequenced (1..16)
PHASE_WIDTH, 6, width of phase input
PHASE_MAX, 32, full-midgame phase value; must be a power of two
TIMEOUT_CYCLES, 64, maximum WAIT cycles before an error completion

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
board_valid  in  1  request: board and phase valid this cycle
board  in  `BOARD_WIDTH  board to evaluate
phase  in  PHASE_WIDTH  game phase, 0 = pure endgame, PHASE_MAX = pure midgame
clear_eval  in  1  consumer done with the result; also aborts an in-flight evaluation
busy  out  1  high in every state except IDLE
eval  out  EVAL_WIDTH  signed tapered score, white-positive
eval_error  out  1  completion was due to timeout
eval_valid  out  1  eval/eval_error valid; held until clear_eval
unit_board_valid  out  1  one-cycle launch pulse to all units
unit_board  out  `BOARD_WIDTH  latched board, stable from launch until IDLE
unit_clear_eval  out  1  one-cycle clear pulse to all units
unit_eval_mg  in  NUM_EVAL*EVAL_WIDTH  packed unit midgame terms; unit k at [k*EVAL_WIDTH+:EVAL_WIDTH]
unit_eval_eg  in  NUM_EVAL*EVAL_WIDTH  packed unit endgame terms
unit_eval_valid  in  NUM_EVAL  per-unit valid; units hold it until cleared

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE.
  - All outputs 0: eval, eval_valid, eval_error, busy, unit_board_valid, unit_clear_eval, unit_board.
  - Internal seen-mask, sums and timeout counter cleared.
- IDLE:
  - On board_valid, latch board into unit_board and latch phase, clamped to PHASE_MAX if larger.
  - Pulse unit_board_valid for exactly one cycle and go to WAIT.
- WAIT:
  - Sticky seen-mask |= unit_eval_valid.
  - Timeout counter increments each cycle.
  - When the mask is all ones, go to SUM.
  - If instead the counter reaches TIMEOUT_CYCLES-1, go to DONE with eval=0 and eval_error=1.
- SUM (1 cycle):
  - mg_sum and eg_sum are the signed sums of all unit terms, computed at EVAL_WIDTH+4 bits. No overflow is possible for NUM_EVAL ≤ 16.
- TAPER (1 cycle):
  - t = (mg_sum*phase + eg_sum*(PHASE_MAX-phase)) >>> log2(PHASE_MAX). This is an arithmetic shift, so it floors toward −inf.
  - The product width is sufficient for no intermediate overflow.
  - t is saturated to the signed EVAL_WIDTH range and registered into eval.
- DONE:
  - On entry, eval_valid=1 and unit_clear_eval pulses for one cycle.
  - Stay in DONE until clear_eval; then eval_valid=0, eval_error=0, go to IDLE.
- Latency: eval_valid rises exactly 3 cycles after the first cycle in which all unit_eval_valid bits have been seen.
- board_valid outside IDLE is ignored (not queued). The caller must gate on busy.
- clear_eval in WAIT, SUM or TAPER: abort. Pulse unit_clear_eval, produce no result (eval_valid stays 0), go to IDLE next cycle.
- clear_eval in IDLE: no effect.
- clear_eval and board_valid in the same cycle in DONE: the clear is taken; board_valid is ignored.
- A unit_eval_valid bit dropping during WAIT does not clear its seen-mask bit.

Decomposition:
- Shared include vchess.vh gains:
  - state encodings (IDLE, WAIT, SUM, TAPER, DONE)
  - EVAL_PHASE_MAX default
- One sub-module, eval_taper: the combinational taper multiply, shift and saturate. It is registered by the parent.

Test Plan:
1. Reset for 3 cycles mid-WAIT -> all outputs 0, busy=0; the next board_valid is accepted normally.
2. NUM_EVAL=4, phase=32, mg={35,20,-10,0}, eg={0,0,0,0}, all units valid 5 cycles after launch -> eval=45, eval_error=0, eval_valid high 3 cycles after the valids, unit_clear_eval pulsed once.
3. Taper values:
   - phase=16, mg sum 40, eg sum 20 -> eval=30.
   - phase=16, mg sum -35, eg sum 0 -> eval=-18 (floor).
   - phase=40 (clamped to 32), mg sum 7, eg sum 99 -> eval=7.
4. Staggered valids: units 0-2 valid at +5, unit 3 valid at +15 -> eval_valid exactly at unit-3 cycle+3. A second board_valid while busy is ignored, with no second launch pulse.
5. Unit 2 never valid, TIMEOUT_CYCLES=64 -> DONE after 64 WAIT cycles with eval=0, eval_error=1. clear_eval -> IDLE, eval_valid=0.
6. clear_eval during WAIT -> unit_clear_eval pulse, IDLE next cycle, eval_valid never rises. A saturation case (EVAL_WIDTH=8, mg sum 4*100, phase=32) -> eval=127.
